// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with registered, mutually aligned sync/blank/strobe outputs
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_err
    $error("vga_timing_gen: line or frame total exceeds 10-bit counter range");
  end
  // 11-bit thresholds so a window edge equal to 1024 still compares correctly
  localparam logic [9:0]  H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] HS0   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] VS0   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1   = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic       h_wrap, in_hs, in_vs, in_blank;
  always_comb begin
    h_wrap   = h_cnt == H_MAX;
    h_nxt    = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt    = !h_wrap ? v_cnt : (v_cnt == V_MAX ? 10'd0 : v_cnt + 10'd1);
    in_hs    = {1'b0, h_cnt} >= HS0 && {1'b0, h_cnt} < HS1;
    in_vs    = {1'b0, v_cnt} >= VS0 && {1'b0, v_cnt} < VS1;
    in_blank = {1'b0, h_cnt} >= HA || {1'b0, v_cnt} >= VA;
  end
  // outputs describe the pixel the counters held before this edge's increment
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      hsync       <= in_hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_vs ? SYNC_POL : ~SYNC_POL;
      blank       <= in_blank;
      line_start  <= h_cnt == 10'd0;
      frame_start <= h_cnt == 10'd0 && v_cnt == 10'd0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule
